regfile_wb_arbiter: RTL and testbench

Write-back controller for the pipeline's 16×32 register file. Two write-back sources, the ALU stage and the load/memory stage, share the file's single write port. This block arbitrates between them and drives the port through an output register. It also keeps a load scoreboard that stalls decode when a source register is still waiting on an outstanding load or a queued write.

---
 rtl/rf_ctrl_pkg.sv | 14 +
 rtl/rf_scoreboard.sv | 61 ++++++
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file write-back controller.
package rf_ctrl_pkg;

   localparam int INDEX_BIT_WIDTH = 4;
   localparam int DATA_BIT_WIDTH  = 32;
   localparam int N_REGS          = 1 << INDEX_BIT_WIDTH;

   // Identifies a write-back requester; used as the round-robin priority pointer.
   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Load scoreboard: one pending bit per register, set when decode issues a
// load and cleared when that load's write-back is accepted. Also flags
// protocol errors and provides the two pending lookups used for stalling.
module rf_scoreboard
   import rf_ctrl_pkg::*;
#(
   parameter int INDEX_BIT_WIDTH = rf_ctrl_pkg::INDEX_BIT_WIDTH,
   parameter int N_REGS          = 1 << INDEX_BIT_WIDTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       loadIssue,
   input  logic [INDEX_BIT_WIDTH-1:0] loadIndex,
   input  logic                       memAccept,
   input  logic [INDEX_BIT_WIDTH-1:0] memIndex,
   input  logic [INDEX_BIT_WIDTH-1:0] rdIndex1,
   input  logic [INDEX_BIT_WIDTH-1:0] rdIndex2,
   output logic                       pend1,
   output logic                       pend2,
   output logic                       sbErr
);

   logic [N_REGS-1:0] pending;
   logic [N_REGS-1:0] nextPending;
   logic              loadErr;
   logic              memErr;

   // Next pending vector: the clear is applied first so a same-cycle set wins.
   always_comb begin
      nextPending = pending;
      if (memAccept) begin
         nextPending[memIndex] = 1'b0;
      end
      if (loadIssue) begin
         nextPending[loadIndex] = 1'b1;
      end
   end

   // A new load to a register whose previous load is retiring this very cycle
   // is legitimate; only a load on top of a still-outstanding one is an error.
   assign loadErr = loadIssue && pending[loadIndex] &&
                    !(memAccept && (memIndex == loadIndex));
   assign memErr  = memAccept && !pending[memIndex];

   assign pend1 = pending[rdIndex1];
   assign pend2 = pending[rdIndex2];

   // Pending vector and sticky error flag, both cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending <= '0;
         sbErr   <= 1'b0;
      end else begin
         pending <= nextPending;
         if (loadErr || memErr) begin
            sbErr <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back controller for the register file: arbitrates ALU and load
// write-backs onto the single write port through an output register and
// generates the decode stall from the load scoreboard and in-flight write.
// Build option: define RFARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise the memory requester has fixed priority.
module regfile_wb_arbiter
   import rf_ctrl_pkg::*;
#(
   parameter int INDEX_BIT_WIDTH = rf_ctrl_pkg::INDEX_BIT_WIDTH,
   parameter int DATA_BIT_WIDTH  = rf_ctrl_pkg::DATA_BIT_WIDTH,
   parameter int N_REGS          = 1 << INDEX_BIT_WIDTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       aluValid,
   input  logic [INDEX_BIT_WIDTH-1:0] aluIndex,
   input  logic [DATA_BIT_WIDTH-1:0]  aluData,
   output logic                       aluReady,
   input  logic                       memValid,
   input  logic [INDEX_BIT_WIDTH-1:0] memIndex,
   input  logic [DATA_BIT_WIDTH-1:0]  memData,
   output logic                       memReady,
   input  logic                       loadIssue,
   input  logic [INDEX_BIT_WIDTH-1:0] loadIndex,
   input  logic [INDEX_BIT_WIDTH-1:0] rdIndex1,
   input  logic [INDEX_BIT_WIDTH-1:0] rdIndex2,
   input  logic                       rdUse1,
   input  logic                       rdUse2,
   output logic                       stall,
   output logic                       wrtEn,
   output logic [INDEX_BIT_WIDTH-1:0] wrtIndex,
   output logic [DATA_BIT_WIDTH-1:0]  dataIn,
   output logic                       sbErr
);

   logic aluAccept;
   logic memAccept;
   logic pend1;
   logic pend2;

`ifdef RFARB_ROUND_ROBIN_EN
   req_t rrPtr;

   assign aluReady = !reset && aluValid && (!memValid || (rrPtr == REQ_ALU));
   assign memReady = !reset && memValid && (!aluValid || (rrPtr == REQ_MEM));

   // Hand priority to the other requester after every contested grant.
   always_ff @(posedge clk) begin
      if (reset) begin
         rrPtr <= REQ_ALU;
      end else if (aluValid && memValid) begin
         rrPtr <= (rrPtr == REQ_ALU) ? REQ_MEM : REQ_ALU;
      end
   end
`else
   assign aluReady = !reset && aluValid && !memValid;
   assign memReady = !reset && memValid;
`endif

   assign aluAccept = aluValid && aluReady;
   assign memAccept = memValid && memReady;

   // Output register driving the register-file write port; the grant is
   // one-hot, so at most one accept branch is ever taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         wrtEn    <= 1'b0;
         wrtIndex <= '0;
         dataIn   <= '0;
      end else if (memAccept) begin
         wrtEn    <= 1'b1;
         wrtIndex <= memIndex;
         dataIn   <= memData;
      end else if (aluAccept) begin
         wrtEn    <= 1'b1;
         wrtIndex <= aluIndex;
         dataIn   <= aluData;
      end else begin
         wrtEn    <= 1'b0;
      end
   end

   rf_scoreboard #(
      .INDEX_BIT_WIDTH(INDEX_BIT_WIDTH),
      .N_REGS         (N_REGS)
   ) scoreboard (
      .clk      (clk),
      .reset    (reset),
      .loadIssue(loadIssue),
      .loadIndex(loadIndex),
      .memAccept(memAccept),
      .memIndex (memIndex),
      .rdIndex1 (rdIndex1),
      .rdIndex2 (rdIndex2),
      .pend1    (pend1),
      .pend2    (pend2),
      .sbErr    (sbErr)
   );

   // The register file has no bypass, so a write still in the output register
   // must also hold decode until it has landed.
   assign stall = (rdUse1 && (pend1 || (wrtEn && (wrtIndex == rdIndex1)))) ||
                  (rdUse2 && (pend2 || (wrtEn && (wrtIndex == rdIndex2))));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed stimulus, with expected
// write-backs queued by the stimulus and retired by a separate monitor.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        aluValid;
   logic [3:0]  aluIndex;
   logic [31:0] aluData;
   logic        aluReady;
   logic        memValid;
   logic [3:0]  memIndex;
   logic [31:0] memData;
   logic        memReady;
   logic        loadIssue;
   logic [3:0]  loadIndex;
   logic [3:0]  rdIndex1;
   logic [3:0]  rdIndex2;
   logic        rdUse1;
   logic        rdUse2;
   logic        stall;
   logic        wrtEn;
   logic [3:0]  wrtIndex;
   logic [31:0] dataIn;
   logic        sbErr;

   typedef struct packed {
      logic [3:0]  idx;
      logic [31:0] data;
   } wb_t;

   wb_t expQ[$];
   int  total = 0;
   int  bad   = 0;

   regfile_wb_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .aluValid (aluValid),
      .aluIndex (aluIndex),
      .aluData  (aluData),
      .aluReady (aluReady),
      .memValid (memValid),
      .memIndex (memIndex),
      .memData  (memData),
      .memReady (memReady),
      .loadIssue(loadIssue),
      .loadIndex(loadIndex),
      .rdIndex1 (rdIndex1),
      .rdIndex2 (rdIndex2),
      .rdUse1   (rdUse1),
      .rdUse2   (rdUse2),
      .stall    (stall),
      .wrtEn    (wrtEn),
      .wrtIndex (wrtIndex),
      .dataIn   (dataIn),
      .sbErr    (sbErr)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      total++;
      if (actual !== required) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, required, $time);
      end
   endtask

   task automatic applyStimulus(input logic aV, input logic [3:0] aI, input logic [31:0] aD,
                                input logic mV, input logic [3:0] mI, input logic [31:0] mD,
                                input logic lIss, input logic [3:0] lIdx);
      aluValid  = aV;
      aluIndex  = aI;
      aluData   = aD;
      memValid  = mV;
      memIndex  = mI;
      memData   = mD;
      loadIssue = lIss;
      loadIndex = lIdx;
   endtask

   task automatic setRead(input logic [3:0] r1, input logic u1,
                          input logic [3:0] r2, input logic u2);
      rdIndex1 = r1;
      rdUse1   = u1;
      rdIndex2 = r2;
      rdUse2   = u2;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      setRead(0, 0, 0, 0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Monitor: every write the DUT presents must match the oldest expected write.
   always @(negedge clk) begin
      if (wrtEn === 1'b1) begin
         if (expQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpectedWrite: got idx=%0d data=0x%0h, want none", wrtIndex, dataIn);
         end else begin
            wb_t e;
            e = expQ.pop_front();
            checkOutput("wbIndex", {28'd0, wrtIndex}, {28'd0, e.idx});
            checkOutput("wbData", dataIn, e.data);
         end
      end
   end

   initial begin
      logic aluGrant;
      int   waitCount;

      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      setRead(0, 0, 0, 0);
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      #1;

      // Reset state
      checkOutput("rstWrtEn", {31'd0, wrtEn}, 0);
      checkOutput("rstWrtIndex", {28'd0, wrtIndex}, 0);
      checkOutput("rstDataIn", dataIn, 0);
      checkOutput("rstSbErr", {31'd0, sbErr}, 0);
      checkOutput("rstAluReady", {31'd0, aluReady}, 0);
      checkOutput("rstMemReady", {31'd0, memReady}, 0);
      for (int i = 0; i < 16; i++) begin
         setRead(i[3:0], 1, 0, 0);
         #1;
         checkOutput("rstStall", {31'd0, stall}, 0);
      end
      setRead(0, 0, 0, 0);

      // Single ALU write-back and its latency
      applyStimulus(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      #1;
      checkOutput("aluReadySolo", {31'd0, aluReady}, 1);
      checkOutput("memReadyIdle", {31'd0, memReady}, 0);
      expQ.push_back('{idx: 4'd3, data: 32'hDEADBEEF});
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("wrtEnNext", {31'd0, wrtEn}, 1);
      tick();
      #1;
      checkOutput("wrtEnAfter", {31'd0, wrtEn}, 0);

      // Contested requests for four cycles
      doReset();
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 1, 32'hA11A0001, 1, 2, 32'hBEE00002, 0, 0);
         #1;
`ifdef RFARB_ROUND_ROBIN_EN
         aluGrant = (i % 2 == 0);
`else
         aluGrant = 1'b0;
`endif
         checkOutput("contAluReady", {31'd0, aluReady}, {31'd0, aluGrant});
         checkOutput("contMemReady", {31'd0, memReady}, {31'd0, !aluGrant});
         if (aluGrant) expQ.push_back('{idx: 4'd1, data: 32'hA11A0001});
         else          expQ.push_back('{idx: 4'd2, data: 32'hBEE00002});
         tick();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      tick();

      // Load scoreboard stall and in-flight write stall
      doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 5);
      setRead(5, 1, 0, 0);
      #1;
      checkOutput("stallBeforeLoad", {31'd0, stall}, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("stallPending", {31'd0, stall}, 1);
      applyStimulus(0, 0, 0, 1, 5, 32'h55AA55AA, 0, 0);
      #1;
      checkOutput("memReady5", {31'd0, memReady}, 1);
      checkOutput("stallAcceptCycle", {31'd0, stall}, 1);
      expQ.push_back('{idx: 4'd5, data: 32'h55AA55AA});
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("stallInFlight", {31'd0, stall}, 1);
      tick();
      #1;
      checkOutput("stallDropped", {31'd0, stall}, 0);
      checkOutput("sbErrClean", {31'd0, sbErr}, 0);

      // Same-cycle set and clear, then a stray mem write
      doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 7);
      tick();
      applyStimulus(0, 0, 0, 1, 7, 32'h00000077, 1, 7);
      #1;
      checkOutput("memReady7", {31'd0, memReady}, 1);
      expQ.push_back('{idx: 4'd7, data: 32'h00000077});
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      setRead(7, 1, 0, 0);
      #1;
      checkOutput("sbErrSetWins", {31'd0, sbErr}, 0);
      tick();
      tick();
      checkOutput("pending7Kept", {31'd0, stall}, 1);
      setRead(0, 0, 7, 1);
      #1;
      checkOutput("pending7Port2", {31'd0, stall}, 1);
      setRead(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 1, 9, 32'h00000099, 0, 0);
      expQ.push_back('{idx: 4'd9, data: 32'h00000099});
      #1;
      checkOutput("sbErrBefore", {31'd0, sbErr}, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("sbErrSet", {31'd0, sbErr}, 1);
      tick();
      tick();
      checkOutput("sbErrHeld", {31'd0, sbErr}, 1);

      // Reset while a write sits in the output register
      doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 11);
      tick();
      applyStimulus(1, 6, 32'h00000066, 0, 0, 0, 0, 0);
      #1;
      checkOutput("aluReady6", {31'd0, aluReady}, 1);
      expQ.push_back('{idx: 4'd6, data: 32'h00000066});
      tick();
      reset = 1'b1;
      applyStimulus(1, 8, 32'h00000088, 1, 8, 32'h00000088, 0, 0);
      #1;
      checkOutput("aluReadyInReset", {31'd0, aluReady}, 0);
      checkOutput("memReadyInReset", {31'd0, memReady}, 0);
      tick();
      reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("wrtEnDropped", {31'd0, wrtEn}, 0);
      for (int i = 0; i < 16; i++) begin
         setRead(i[3:0], 1, 0, 0);
         #1;
         checkOutput("postRstStall", {31'd0, stall}, 0);
      end

      // Unused source never stalls
      doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 4);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      setRead(4, 0, 0, 0);
      #1;
      checkOutput("stallNoUse", {31'd0, stall}, 0);
      setRead(4, 1, 0, 0);
      #1;
      checkOutput("stallUse", {31'd0, stall}, 1);

      // Drain: every expected write must have appeared
      waitCount = 0;
      while (expQ.size() != 0 && waitCount < 20) begin
         tick();
         waitCount++;
      end
      checkOutput("drainQueue", expQ.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
